z3_out_neuron: RTL



---
 rtl/z3_out_neuron.sv | 103 ++++++++++
 1 files changed

// File: rtl/z3_out_neuron.sv
// Output-layer neuron: serial MAC of N_HIDDEN (z, w) beats plus bias, then
// round-half-up and saturate to a signed Q6.10 pre-activation with valid/ready.
module z3_out_neuron #(
  parameter int N_HIDDEN = 3,
  parameter int ACC_W    = 28
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  z_in,
  input  logic [15:0] w3,
  input  logic [15:0] b3,
  input  logic        z_valid,
  output logic        z_ready,
  output logic [15:0] y,
  output logic        y_valid,
  input  logic        y_ready,
  output logic        sat
);

  typedef enum logic [1:0] {IDLE, ACC, FINISH, HOLD} state_t;

  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] Y_MIN = -ACC_W'(32768);
  localparam logic        [3:0]       LAST  = 4'(N_HIDDEN);

  state_t                    state;
  logic signed [ACC_W-1:0]   acc;
  logic        [3:0]         cnt;
  logic signed [24:0]        prod;
  logic signed [ACC_W-1:0]   prod_x;
  logic signed [ACC_W-1:0]   bias_x;
  logic signed [ACC_W-1:0]   rnd_sum;
  logic signed [ACC_W-1:0]   r;
  logic                      accept;

  // z is unsigned Q4.4, so a zero MSB keeps it positive in the signed multiply
  assign prod    = $signed({1'b0, z_in}) * $signed(w3);
  assign prod_x  = {{(ACC_W-25){prod[24]}}, prod};
  assign bias_x  = {{(ACC_W-20){b3[15]}}, b3, 4'b0000};
  assign rnd_sum = acc + ACC_W'(8);
  assign r       = rnd_sum >>> 4;
  assign accept  = z_valid & z_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      y       <= '0;
      y_valid <= 1'b0;
      sat     <= 1'b0;
      z_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: if (accept) begin
          acc <= bias_x + prod_x;
          cnt <= 4'd1;
          if (LAST == 4'd1) begin
            state   <= FINISH;
            z_ready <= 1'b0;
          end else begin
            state <= ACC;
          end
        end
        ACC: if (accept) begin
          acc <= acc + prod_x;
          cnt <= cnt + 4'd1;
          if (cnt + 4'd1 == LAST) begin
            state   <= FINISH;
            z_ready <= 1'b0;
          end
        end
        FINISH: begin
          if (r > Y_MAX) begin
            y   <= 16'h7FFF;
            sat <= 1'b1;
          end else if (r < Y_MIN) begin
            y   <= 16'h8000;
            sat <= 1'b1;
          end else begin
            y   <= r[15:0];
            sat <= 1'b0;
          end
          y_valid <= 1'b1;
          state   <= HOLD;
        end
        HOLD: if (y_ready) begin
          // y and sat are left as-is; only the valid drops
          y_valid <= 1'b0;
          z_ready <= 1'b1;
          acc     <= '0;
          cnt     <= '0;
          state   <= IDLE;
        end
        default: begin
          state   <= IDLE;
          z_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
